// File: rtl/ub_affine_read_port.sv
// Affine 3-deep loop-nest read port: walks (i0,i1,i2), issues RAM reads at
// offset + sum(stride*i), and returns data in order through a small output FIFO.
module ub_affine_read_port #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int CTRL_W = 16,
   parameter int DEPTH  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    start,
   input  logic [2:0][CTRL_W-1:0]  extent,
   input  logic [2:0][CTRL_W-1:0]  stride,
   input  logic [CTRL_W-1:0]       offset,
   output logic                    rd_ren,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic [DATA_W-1:0]       rd_data,
   output logic [3*CTRL_W-1:0]     ctrl_vars,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic                    busy,
   output logic                    done
);

   localparam int PW    = 2 * CTRL_W;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   typedef logic [2:0][CTRL_W-1:0] vec3_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state_q, state_d;
   vec3_t              ext_q, str_q, idx_q, idx_nxt;
   logic [CTRL_W-1:0]  off_q;
   logic [2:0]         at_max;
   logic               last_issue, ext_zero, issue_ok, drain_empty;
   logic               vld_p1, push, pop;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W:0]     occ;
   logic [DATA_W-1:0]  fifo_p2 [DEPTH];

   function automatic logic [PW-1:0] widen(input logic [CTRL_W-1:0] v);
      return {{CTRL_W{1'b0}}, v};
   endfunction

   // Full-width sum, then wrap to the RAM address space.
   function automatic logic [ADDR_W-1:0] affine_addr(input vec3_t s, input vec3_t i,
                                                     input logic [CTRL_W-1:0] o);
      return ADDR_W'(widen(o) + widen(s[0]) * widen(i[0])
                              + widen(s[1]) * widen(i[1])
                              + widen(s[2]) * widen(i[2]));
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      for (int k = 0; k < 3; k++)
         at_max[k] = (idx_q[k] == ext_q[k] - CTRL_W'(1));
      idx_nxt    = idx_q;
      idx_nxt[2] = at_max[2] ? '0 : idx_q[2] + CTRL_W'(1);
      if (at_max[2])
         idx_nxt[1] = at_max[1] ? '0 : idx_q[1] + CTRL_W'(1);
      if (at_max[2] && at_max[1])
         idx_nxt[0] = at_max[0] ? '0 : idx_q[0] + CTRL_W'(1);
   end

   assign last_issue = &at_max;
   assign ext_zero   = (ext_q[0] == '0) || (ext_q[1] == '0) || (ext_q[2] == '0);
   assign occ        = {1'b0, cnt_q} + (CNT_W + 1)'(vld_p1);
   assign issue_ok   = occ < (CNT_W + 1)'(DEPTH);
   // The final entry may leave in the same cycle done fires.
   assign drain_empty = !vld_p1 && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && out_ready));

   assign rd_addr   = affine_addr(str_q, idx_q, off_q);
   assign ctrl_vars = {idx_q[0], idx_q[1], idx_q[2]};
   assign busy      = (state_q != IDLE) && !rst;
   assign out_valid = (cnt_q != '0) && !rst;
   assign out_data  = fifo_p2[rd_ptr_q];
   assign push      = vld_p1;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      rd_ren  = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = RUN;
         RUN: begin
            if (ext_zero) begin
               state_d = DRAIN;
            end else if (issue_ok) begin
               rd_ren = 1'b1;
               if (last_issue) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_empty) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         done    = 1'b0;
      end
      if (rst) begin
         state_d = IDLE;
         rd_ren  = 1'b0;
         done    = 1'b0;
      end
   end

   // p0 -> p1: issue registered; read data returns alongside vld_p1
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         vld_p1   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         vld_p1  <= rd_ren;
         if (rd_ren) idx_q <= idx_nxt;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // p1 -> p2: returning data lands in the output FIFO
   always_ff @(posedge clk) begin
      if (state_q == IDLE && start) begin
         ext_q <= extent;
         str_q <= stride;
         off_q <= offset;
      end
      if (push) fifo_p2[wr_ptr_q] <= rd_data;
   end

endmodule

// File: tb/tb_ub_affine_read_port.sv
// Directed bench for ub_affine_read_port with a one-cycle-latency RAM model
// whose word at address a is {4'hC, a}.
module tb_ub_affine_read_port;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              start = 1'b0;
   logic              out_ready = 1'b1;
   logic [2:0][15:0]  extent = '0;
   logic [2:0][15:0]  stride = '0;
   logic [15:0]       offset = '0;
   logic              rd_ren;
   logic [11:0]       rd_addr;
   logic [15:0]       rd_data = '0;
   logic [47:0]       ctrl_vars;
   logic              out_valid;
   logic [15:0]       out_data;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] iss_addr[$];
   logic [47:0] iss_vars[$];
   int          iss_cyc[$];
   logic [15:0] out_q[$];
   int          out_cyc[$];
   int          done_cnt, done_cyc, busy_cnt, max_pend, unstable, flush_cyc;
   logic        ov_after, ren_after;

   ub_affine_read_port #(.DATA_W(16), .ADDR_W(12), .CTRL_W(16), .DEPTH(3)) dut (
      .clk(clk), .rst(rst), .flush(flush), .start(start),
      .extent(extent), .stride(stride), .offset(offset),
      .rd_ren(rd_ren), .rd_addr(rd_addr), .rd_data(rd_data),
      .ctrl_vars(ctrl_vars), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_ren) rd_data <= {4'hC, rd_addr};

   // Cycle 0 is the start cycle; called and returns at a falling edge.
   task automatic run_sweep(input logic [15:0] e0, e1, e2, s0, s1, s2, off,
                            input int rlo, rhi, flush_iss, start2, ncyc);
      int pops = 0;
      logic stalled = 1'b0;
      logic [15:0] held = '0;
      iss_addr.delete(); iss_vars.delete(); iss_cyc.delete();
      out_q.delete(); out_cyc.delete();
      done_cnt = 0; done_cyc = -1; busy_cnt = 0; max_pend = 0; unstable = 0;
      flush_cyc = -1; ov_after = 1'bx; ren_after = 1'bx;
      extent[0] = e0; extent[1] = e1; extent[2] = e2;
      stride[0] = s0; stride[1] = s1; stride[2] = s2;
      offset = off;
      for (int c = 0; c < ncyc; c++) begin
         start     = (c == 0) || (c == start2);
         out_ready = !(c >= rlo && c <= rhi);
         flush     = 1'b0;
         #1;
         if (stalled && (!out_valid || out_data !== held)) unstable++;
         stalled = out_valid && !out_ready;
         held    = out_data;
         if (rd_ren) begin
            iss_addr.push_back(rd_addr);
            iss_vars.push_back(ctrl_vars);
            iss_cyc.push_back(c);
            if (iss_addr.size() == flush_iss) begin
               flush = 1'b1;
               flush_cyc = c;
            end
         end
         if (flush_cyc >= 0 && c == flush_cyc + 1) begin
            ov_after  = out_valid;
            ren_after = rd_ren;
         end
         if (iss_addr.size() - pops > max_pend) max_pend = iss_addr.size() - pops;
         if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            out_cyc.push_back(c);
            pops++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (busy) busy_cnt++;
         @(negedge clk);
      end
      start = 1'b0; flush = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; flush = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (rd_ren !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ren: got %b expected 0", rd_ren); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (ctrl_vars !== 48'h0) begin n_fail++; $display("FAIL reset_ctrl_vars: got %h expected 0", ctrl_vars); end
      @(negedge clk);
      rst = 1'b0; start = 1'b0; flush = 1'b0;
      @(negedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy got %b expected 0", busy); end
      @(negedge clk);
   endtask

   task automatic test_basic_sweep;
      logic [11:0] ea [6] = '{12'd5, 12'd6, 12'd7, 12'd69, 12'd70, 12'd71};
      logic [47:0] ev [6] = '{48'h0000_0000_0000, 48'h0000_0000_0001, 48'h0000_0000_0002,
                              48'h0000_0001_0000, 48'h0000_0001_0001, 48'h0000_0001_0002};
      logic [15:0] ed [6] = '{16'hC005, 16'hC006, 16'hC007, 16'hC045, 16'hC046, 16'hC047};
      run_sweep(16'd1, 16'd2, 16'd3, 16'd0, 16'd64, 16'd1, 16'd5, -1, -1, -1, -1, 14);
      n_checks++; if (iss_addr.size() != 6) begin n_fail++; $display("FAIL basic_issue_count: got %0d expected 6", iss_addr.size()); end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (k >= iss_addr.size() || iss_addr[k] !== ea[k]) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", k, iss_addr[k], ea[k]); end
         n_checks++;
         if (k >= iss_vars.size() || iss_vars[k] !== ev[k]) begin n_fail++; $display("FAIL basic_vars[%0d]: got %h expected %h", k, iss_vars[k], ev[k]); end
         n_checks++;
         if (k >= out_q.size() || out_q[k] !== ed[k]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", k, out_q[k], ed[k]); end
      end
      n_checks++; if (iss_cyc.size() < 6 || iss_cyc[0] != 1 || iss_cyc[5] != 6) begin n_fail++; $display("FAIL basic_issue_cycles: got first %0d last %0d expected 1 and 6", iss_cyc[0], iss_cyc[5]); end
      n_checks++; if (out_cyc.size() < 1 || out_cyc[0] != 3) begin n_fail++; $display("FAIL basic_first_out_cycle: got %0d expected 3", out_cyc[0]); end
      n_checks++; if (done_cnt != 1 || done_cyc != 8) begin n_fail++; $display("FAIL basic_done: got count %0d cycle %0d expected 1 at 8", done_cnt, done_cyc); end
   endtask

   task automatic test_backpressure;
      logic [11:0] ea [6] = '{12'd5, 12'd6, 12'd7, 12'd69, 12'd70, 12'd71};
      logic [15:0] ed [6] = '{16'hC005, 16'hC006, 16'hC007, 16'hC045, 16'hC046, 16'hC047};
      run_sweep(16'd1, 16'd2, 16'd3, 16'd0, 16'd64, 16'd1, 16'd5, 3, 8, -1, -1, 30);
      n_checks++; if (out_q.size() != 6) begin n_fail++; $display("FAIL bp_out_count: got %0d expected 6", out_q.size()); end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (k >= iss_addr.size() || iss_addr[k] !== ea[k]) begin n_fail++; $display("FAIL bp_addr[%0d]: got %0d expected %0d", k, iss_addr[k], ea[k]); end
         n_checks++;
         if (k >= out_q.size() || out_q[k] !== ed[k]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", k, out_q[k], ed[k]); end
      end
      n_checks++; if (max_pend > 3) begin n_fail++; $display("FAIL bp_max_pending: got %0d expected at most 3", max_pend); end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
      n_checks++; if (iss_cyc.size() < 6 || iss_cyc[5] <= 6) begin n_fail++; $display("FAIL bp_stall: last issue cycle %0d expected later than 6", iss_cyc[5]); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", done_cnt); end
   endtask

   task automatic test_wrap;
      logic [11:0] ea [8] = '{12'd4090, 12'd4091, 12'd4092, 12'd4093, 12'd4094, 12'd4095, 12'd0, 12'd1};
      logic [15:0] ed [8] = '{16'hCFFA, 16'hCFFB, 16'hCFFC, 16'hCFFD, 16'hCFFE, 16'hCFFF, 16'hC000, 16'hC001};
      run_sweep(16'd1, 16'd1, 16'd8, 16'd0, 16'd0, 16'd1, 16'd4090, -1, -1, -1, -1, 16);
      n_checks++; if (iss_addr.size() != 8) begin n_fail++; $display("FAIL wrap_issue_count: got %0d expected 8", iss_addr.size()); end
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (k >= iss_addr.size() || iss_addr[k] !== ea[k]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, iss_addr[k], ea[k]); end
         n_checks++;
         if (k >= out_q.size() || out_q[k] !== ed[k]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, out_q[k], ed[k]); end
      end
      n_checks++; if (done_cnt != 1 || done_cyc != 10) begin n_fail++; $display("FAIL wrap_done: got count %0d cycle %0d expected 1 at 10", done_cnt, done_cyc); end
   endtask

   task automatic test_zero_extent;
      run_sweep(16'd2, 16'd0, 16'd3, 16'd1, 16'd1, 16'd1, 16'd0, -1, -1, -1, -1, 6);
      n_checks++; if (iss_addr.size() != 0) begin n_fail++; $display("FAIL zero_no_reads: got %0d reads expected 0", iss_addr.size()); end
      n_checks++; if (done_cnt != 1 || done_cyc != 2) begin n_fail++; $display("FAIL zero_done: got count %0d cycle %0d expected 1 at 2", done_cnt, done_cyc); end
      n_checks++; if (busy_cnt != 2) begin n_fail++; $display("FAIL zero_busy: got %0d cycles expected 2", busy_cnt); end
   endtask

   task automatic test_abort;
      run_sweep(16'd1, 16'd2, 16'd3, 16'd0, 16'd64, 16'd1, 16'd5, -1, -1, 3, -1, 10);
      n_checks++; if (iss_addr.size() != 3) begin n_fail++; $display("FAIL abort_issue_count: got %0d expected 3", iss_addr.size()); end
      n_checks++; if (ren_after !== 1'b0) begin n_fail++; $display("FAIL abort_rd_ren_next: got %b expected 0", ren_after); end
      n_checks++; if (ov_after !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid_next: got %b expected 0", ov_after); end
      n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
      n_checks++; if (busy_cnt != 3) begin n_fail++; $display("FAIL abort_busy: got %0d cycles expected 3", busy_cnt); end
      run_sweep(16'd1, 16'd2, 16'd3, 16'd0, 16'd64, 16'd1, 16'd5, -1, -1, -1, -1, 14);
      n_checks++; if (iss_vars.size() < 1 || iss_vars[0] !== 48'h0) begin n_fail++; $display("FAIL abort_restart_vars: got %h expected 0", iss_vars[0]); end
      n_checks++; if (iss_addr.size() != 6 || iss_addr[0] !== 12'd5 || iss_addr[5] !== 12'd71) begin n_fail++; $display("FAIL abort_restart_addr: got count %0d first %0d expected 6 reads from 5 to 71", iss_addr.size(), iss_addr[0]); end
      n_checks++; if (out_q.size() != 6 || out_q[0] !== 16'hC005) begin n_fail++; $display("FAIL abort_restart_data: got count %0d first %h expected 6 from C005", out_q.size(), out_q[0]); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL abort_restart_done: got %0d pulses expected 1", done_cnt); end
   endtask

   task automatic test_start_ignored;
      logic [11:0] ea [6] = '{12'd5, 12'd6, 12'd7, 12'd69, 12'd70, 12'd71};
      run_sweep(16'd1, 16'd2, 16'd3, 16'd0, 16'd64, 16'd1, 16'd5, -1, -1, -1, 3, 14);
      n_checks++; if (iss_addr.size() != 6) begin n_fail++; $display("FAIL restart_issue_count: got %0d expected 6", iss_addr.size()); end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (k >= iss_addr.size() || iss_addr[k] !== ea[k]) begin n_fail++; $display("FAIL restart_addr[%0d]: got %0d expected %0d", k, iss_addr[k], ea[k]); end
      end
      n_checks++; if (done_cnt != 1 || done_cyc != 8) begin n_fail++; $display("FAIL restart_done: got count %0d cycle %0d expected 1 at 8", done_cnt, done_cyc); end
   endtask

   task automatic test_reset_mid_sweep;
      int seen_done = 0;
      int seen_busy = 0;
      extent[0] = 16'd1; extent[1] = 16'd2; extent[2] = 16'd3;
      stride[0] = 16'd0; stride[1] = 16'd64; stride[2] = 16'd1;
      offset = 16'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (rd_ren !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_ren: got %b expected 0", rd_ren); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      @(negedge clk);
      #1;
      n_checks++; if (ctrl_vars !== 48'h0) begin n_fail++; $display("FAIL midrst_ctrl_vars: got %h expected 0", ctrl_vars); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (done) seen_done++;
         if (busy) seen_busy++;
         @(negedge clk);
      end
      n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen_done); end
      n_checks++; if (seen_busy != 0) begin n_fail++; $display("FAIL midrst_idle: got %0d busy cycles expected 0", seen_busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_sweep();
      test_backpressure();
      test_wrap();
      test_zero_extent();
      test_abort();
      test_start_ignored();
      test_reset_mid_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
